// File: rtl/base_skid_buf.sv
// base_skid_buf: two-entry valid/ready register stage; registers data/valid and ready paths.
module base_skid_buf #(
  parameter int DAT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [DAT_W-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DAT_W-1:0] out_dat,
  output logic [1:0]       occ
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [DAT_W-1:0] main_q, main_d, skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             push, pop;
  assign out_vld = state_q != EMPTY;
  assign in_rdy  = rdy_q & (state_q != FULL);
  assign out_dat = main_q;
  assign occ     = state_q;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    rdy_d   = 1'b1;
    case (state_q)
      EMPTY: if (push) begin
        main_d  = in_dat;
        state_d = ONE;
      end
      ONE: if (push && pop) main_d = in_dat;
      else if (push) begin
        skid_d  = in_dat;
        state_d = FULL;
      end
      else if (pop) state_d = EMPTY;
      FULL: if (pop) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end
endmodule

// File: tb/tb_base_skid_buf.sv
// tb_base_skid_buf: directed and random self-checking bench for base_skid_buf.
module tb_base_skid_buf;
  logic       clk = 1'b0;
  logic       rst_n, in_vld, in_rdy, out_vld, out_rdy;
  logic [7:0] in_dat, out_dat;
  logic [1:0] occ;
  int checks = 0, errors = 0;
  base_skid_buf #(.DAT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .occ(occ)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] q[$];
    logic [7:0] nxt, held, exp_dat;
    logic       push, pop, stalled;
    rst_n = 1'b0; in_vld = 1'b1; in_dat = 8'hAA; out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out_vld", out_vld, 0);
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_out_dat", out_dat, 8'h00);
      chk("rst_occ", occ, 0);
    end
    rst_n = 1'b1;
    chk("rel1_in_rdy", in_rdy, 0);
    step();
    chk("rel2_in_rdy", in_rdy, 1);
    chk("rel2_no_capture", out_vld, 0);
    chk("rel2_out_dat", out_dat, 8'h00);
    // streaming with the consumer always ready
    out_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_vld = 1'b1; in_dat = 8'(i);
      step();
      chk("strm_out_vld", out_vld, 1);
      chk("strm_out_dat", out_dat, 32'(i));
      chk("strm_in_rdy", in_rdy, 1);
      chk("strm_occ", occ, 1);
    end
    in_vld = 1'b0;
    step();
    chk("strm_empty_occ", occ, 0);
    chk("strm_empty_vld", out_vld, 0);
    out_rdy = 1'b0; in_vld = 1'b1; in_dat = 8'h11;
    step();
    chk("bp1_occ", occ, 1);
    chk("bp1_out_dat", out_dat, 8'h11);
    chk("bp1_in_rdy", in_rdy, 1);
    in_dat = 8'h22;
    step();
    chk("bp2_occ", occ, 2);
    chk("bp2_in_rdy", in_rdy, 0);
    chk("bp2_out_dat", out_dat, 8'h11);
    in_dat = 8'h33;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp3_occ", occ, 2);
      chk("bp3_in_rdy", in_rdy, 0);
      chk("bp3_out_dat", out_dat, 8'h11);
    end
    out_rdy = 1'b1;
    step();
    chk("dr1_out_dat", out_dat, 8'h22);
    chk("dr1_occ", occ, 1);
    chk("dr1_in_rdy", in_rdy, 1);
    step();
    chk("dr2_out_dat", out_dat, 8'h33);
    chk("dr2_occ", occ, 1);
    in_vld = 1'b0;
    step();
    chk("dr3_out_vld", out_vld, 0);
    chk("dr3_occ", occ, 0);
    // random stress against a queue model; last cycles drain
    nxt = 8'h00;
    for (int c = 0; c < 10010; c++) begin
      in_vld  = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_rdy = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_dat  = nxt;
      chk("rnd_in_rdy", in_rdy, (q.size() < 2) ? 1 : 0);
      chk("rnd_out_vld", out_vld, (q.size() != 0) ? 1 : 0);
      push = in_vld & in_rdy;
      pop  = out_vld & out_rdy;
      if (pop) begin
        exp_dat = q.pop_front();
        chk("rnd_order", out_dat, exp_dat);
      end
      if (push) begin
        q.push_back(in_dat);
        nxt++;
      end
      stalled = out_vld & ~out_rdy;
      held    = out_dat;
      step();
      if (stalled) begin
        chk("rnd_stall_vld", out_vld, 1);
        chk("rnd_stall_dat", out_dat, held);
      end
      chk("rnd_occ", occ, q.size());
    end
    chk("rnd_drained", occ, 0);
    out_rdy = 1'b0; in_vld = 1'b1; in_dat = 8'h5A;
    step();
    in_dat = 8'h6B;
    step();
    chk("mr_full", occ, 2);
    rst_n = 1'b0; out_rdy = 1'b1;
    step();
    chk("mr_occ", occ, 0);
    chk("mr_out_vld", out_vld, 0);
    chk("mr_out_dat", out_dat, 8'h00);
    rst_n = 1'b1; out_rdy = 1'b0; in_dat = 8'h77;
    step();
    chk("mr_rel_vld", out_vld, 0);
    chk("mr_rel_rdy", in_rdy, 1);
    step();
    chk("mr_first_vld", out_vld, 1);
    chk("mr_first_dat", out_dat, 8'h77);
    in_vld = 1'b0; out_rdy = 1'b1;
    step();
    chk("mr_end_occ", occ, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
